// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller: FSM states, instruction
// opcodes, R-type funct codes and the 4-bit AluOp encoding the ALU decodes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // AluOp encoding
   localparam logic [3:0] ALUOP_ADD = 4'b0000;
   localparam logic [3:0] ALUOP_SUB = 4'b0010;
   localparam logic [3:0] ALUOP_SLT = 4'b1010;
   localparam logic [3:0] ALUOP_AND = 4'b0100;
   localparam logic [3:0] ALUOP_OR  = 4'b0101;
   localparam logic [3:0] ALUOP_XOR = 4'b0110;
   localparam logic [3:0] ALUOP_NOR = 4'b0111;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational R-type funct -> AluOp decoder with a valid flag for unknown functs.
module alu_op_dec
   import ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       valid
);

   // Map funct to AluOp; unknown functs fall back to ADD with valid low
   always_comb begin
      alu_op = ALUOP_ADD;
      valid  = 1'b1;
      case (funct)
         FUNCT_ADD: alu_op = ALUOP_ADD;
         FUNCT_SUB: alu_op = ALUOP_SUB;
         FUNCT_AND: alu_op = ALUOP_AND;
         FUNCT_OR:  alu_op = ALUOP_OR;
         FUNCT_XOR: alu_op = ALUOP_XOR;
         FUNCT_NOR: alu_op = ALUOP_NOR;
         FUNCT_SLT: alu_op = ALUOP_SLT;
         default:   valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath mux selects and enables, and handshakes with a shared memory.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal
);

   state_t     state, state_next;
   logic [3:0] dec_alu_op;
   logic       dec_valid;
   logic [3:0] alu_op_hold;

   alu_op_dec u_alu_op_dec (
      .funct  (funct),
      .alu_op (dec_alu_op),
      .valid  (dec_valid)
   );

   // State register with synchronous reset taking priority over every transition
   always_ff @(posedge clk) begin
      if (reset) state <= RESET_STATE;
      else       state <= state_next;
   end

   // Capture the EXEC decode so ALUWB drives the same operation
   always_ff @(posedge clk) begin
      if (reset)                 alu_op_hold <= ALUOP_ADD;
      else if (state == S_EXEC)  alu_op_hold <= dec_alu_op;
   end

   // Next-state and Moore output decode; pc_en/ir_write also look at mem_ready and zero
   always_comb begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALUOP_ADD;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b01;
            ir_write   = mem_ready;
            pc_en      = mem_ready;
            state_next = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXEC;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default: begin
                  illegal    = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req    = 1'b1;
            i_or_d     = 1'b1;
            state_next = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            state_next = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            if (dec_valid) begin
               alu_op     = dec_alu_op;
               state_next = S_ALUWB;
            end else begin
               illegal    = 1'b1;
            end
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = alu_op_hold;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = 2'b01;
            pc_en     = zero;
         end
         S_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

endmodule
